// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage
//
// Generic elastic pipeline stage register for the RISC-V pipeline. It replaces
// the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer structs. The packed stage
// struct travels as a flat WIDTH-bit payload.
//
// The stage holds up to two entries: a head register (main) and a skid
// register. The head drives out_data. The skid register absorbs one extra beat,
// so in_ready depends only on registered state and reset, and never on
// out_ready.
//
// Parameters
//   WIDTH  payload width; set it to $bits of the stage struct.
//   BUBBLE payload shown on out_data when the stage is empty or flushed.
//
// Ports
//   clk        rising-edge clock.
//   reset      synchronous, active-high; drops all entries.
//   flush      synchronous squash of all held entries (redirect).
//   in_valid   upstream offers in_data.
//   in_ready   stage can accept this cycle.
//   in_data    upstream payload.
//   out_valid  out_data holds a live entry.
//   out_ready  downstream consumes this cycle.
//   out_data   head-entry payload.
//   count      number of entries held (0, 1 or 2).
//
// Optional build macro PIPE_ELASTIC_STATS_EN adds two outputs:
//   stall_cycles [31:0]  cycles with out_valid & !out_ready; wraps.
//   flush_drops  [15:0]  entries discarded by flushes; saturates.
module pipe_elastic_stage #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
`ifdef PIPE_ELASTIC_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_drops
`endif
);

  // The state encoding equals the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_data, main_nxt;
  logic [WIDTH-1:0] skid_data, skid_nxt;
  logic             in_fire, out_fire;

  assign in_ready  = (state != FULL) & ~reset;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign count     = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;
    if (flush) begin
      // A head that out-fires this cycle has already been taken downstream.
      // Discarding everything is therefore correct, including any in-fire.
      state_nxt = EMPTY;
      main_nxt  = BUBBLE;
      skid_nxt  = BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_nxt  = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_nxt = BUSY;
            main_nxt  = skid_data;
            skid_nxt  = BUBBLE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE;
          skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= BUBBLE;
      skid_data <= BUBBLE;
    end else begin
      state     <= state_nxt;
      main_data <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

`ifdef PIPE_ELASTIC_STATS_EN
  logic [1:0]  drop_n;
  logic [16:0] drop_sum;

  // An entry that out-fires during a flush is delivered, so it is not a drop.
  always_comb begin
    drop_n   = count - {1'b0, out_fire};
    drop_sum = {1'b0, flush_drops} + {15'd0, drop_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_drops  <= 16'd0;
    end else begin
      if (out_valid && !out_ready) stall_cycles <= stall_cycles + 32'd1;
      if (flush) flush_drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed and scoreboard bench for pipe_elastic_stage.
// dut is 32-bit with BUBBLE = 32'h13.
// dut64 is 64-bit and receives random handshake traffic.
module tb_pipe_elastic_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  count;

  logic        r_reset, r_flush, r_in_valid, r_out_ready;
  logic [63:0] r_in_data;
  logic        r_in_ready, r_out_valid;
  logic [63:0] r_out_data;
  logic [1:0]  r_count;

`ifdef PIPE_ELASTIC_STATS_EN
  logic [31:0] stall_cycles, r_stall_cycles;
  logic [15:0] flush_drops, r_flush_drops;
`endif

  localparam logic [31:0] BUB   = 32'h0000_0013;
  localparam logic [63:0] BUB64 = 64'hDEAD_BEEF_0000_0013;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.WIDTH(32), .BUBBLE(BUB)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
`ifdef PIPE_ELASTIC_STATS_EN
    , .stall_cycles(stall_cycles), .flush_drops(flush_drops)
`endif
  );

  pipe_elastic_stage #(.WIDTH(64), .BUBBLE(BUB64)) dut64 (
    .clk(clk), .reset(r_reset), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .count(r_count)
`ifdef PIPE_ELASTIC_STATS_EN
    , .stall_cycles(r_stall_cycles), .flush_drops(r_flush_drops)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    tick(); tick();
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    else pass_cnt++;
    reset = 1'b0; #1;
    total_cnt++;
    if (count !== 2'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== BUB) $display("FAIL reset_out_data: got %h want %h", out_data, BUB); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_high: got %b want 1", in_ready); else pass_cnt++;
`ifdef PIPE_ELASTIC_STATS_EN
    total_cnt++;
    if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else pass_cnt++;
    total_cnt++;
    if (flush_drops !== 16'd0) $display("FAIL reset_drops: got %0d want 0", flush_drops); else pass_cnt++;
`endif
  endtask

  task automatic test_stream;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'(i))
        $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 32'(i));
      else pass_cnt++;
      total_cnt++;
      if (count !== 2'd1) $display("FAIL stream_count[%0d]: got %0d want 1", i, count); else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (count !== 2'd0 || out_data !== BUB)
      $display("FAIL stream_drain: got count=%0d d=%h want 0 %h", count, out_data, BUB);
    else pass_cnt++;
  endtask

  task automatic test_skid;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    total_cnt++;
    if (count !== 2'd1 || out_data !== 32'hA || in_ready !== 1'b1)
      $display("FAIL skid_first: got c=%0d d=%h r=%b want 1 a 1", count, out_data, in_ready);
    else pass_cnt++;
    in_data = 32'hB;
    tick();
    total_cnt++;
    if (count !== 2'd2) $display("FAIL skid_full_count: got %0d want 2", count); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL skid_full_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'hA) $display("FAIL skid_head_kept: got %h want a", out_data); else pass_cnt++;
    // 0xC is offered while FULL drains, so it must be ignored.
    out_ready = 1'b1; in_data = 32'hC;
    tick();
    total_cnt++;
    if (count !== 2'd1 || out_data !== 32'hB || in_ready !== 1'b1)
      $display("FAIL skid_promote: got c=%0d d=%h r=%b want 1 b 1", count, out_data, in_ready);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL skid_empty: got c=%0d v=%b want 0 0 (0xC must not be held)", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    total_cnt++;
    if (count !== 2'd2) $display("FAIL flush_prefill: got %0d want 2", count); else pass_cnt++;
    flush = 1'b1; in_data = 32'h3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB)
      $display("FAIL flush_clear: got c=%0d v=%b d=%h want 0 0 %h", count, out_valid, out_data, BUB);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_discard_in: got v=%b d=%h want v=0", out_valid, out_data);
    else pass_cnt++;
    // A head that out-fires during a flush must still be presented.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
    tick();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1; #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h7)
      $display("FAIL flush_outfire_head: got v=%b d=%h want 1 7", out_valid, out_data);
    else pass_cnt++;
    tick();
    flush = 1'b0;
    total_cnt++;
    if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_outfire_after: got c=%0d v=%b want 0 0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    tick();
    reset = 1'b1; in_data = 32'h66; #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %b want 0", in_ready); else pass_cnt++;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0; #1;
    total_cnt++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b1)
      $display("FAIL rstmid_after: got c=%0d v=%b d=%h r=%b want 0 0 %h 1", count, out_valid, out_data, in_ready, BUB);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_no_output: got v=%b d=%h want v=0", out_valid, out_data);
    else pass_cnt++;
  endtask

`ifdef PIPE_ELASTIC_STATS_EN
  task automatic test_stats;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++;
    if (stall_cycles !== 32'd5) $display("FAIL stats_stall: got %0d want 5", stall_cycles); else pass_cnt++;
    total_cnt++;
    if (flush_drops !== 16'd2) $display("FAIL stats_drops: got %0d want 2", flush_drops); else pass_cnt++;
    // The flushed entry out-fires here, so it does not count as a drop.
    in_valid = 1'b1; in_data = 32'h9;
    tick();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++;
    if (flush_drops !== 16'd2 || stall_cycles !== 32'd5)
      $display("FAIL stats_outfire_flush: got drops=%0d stall=%0d want 2 5", flush_drops, stall_cycles);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random64;
    logic [63:0] q[$];
    logic [63:0] exp_d;
    logic        fired;
    r_reset = 1'b1; r_flush = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0; r_in_data = '0;
    tick(); tick();
    r_reset = 1'b0; #1;
    total_cnt++;
    if (r_count !== 2'd0 || r_out_data !== BUB64 || r_in_ready !== 1'b1)
      $display("FAIL rnd_reset: got c=%0d d=%h r=%b want 0 %h 1", r_count, r_out_data, r_in_ready, BUB64);
    else pass_cnt++;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!r_in_valid && $urandom_range(3) != 0) begin
        r_in_valid = 1'b1;
        r_in_data  = {$urandom, $urandom};
      end
      // in_ready must match the model with out_ready at both levels.
      r_out_ready = 1'b0; #1;
      total_cnt++;
      if (r_in_ready !== (q.size() != 2))
        $display("FAIL rnd_ready_or0[%0d]: got %b want %b", cyc, r_in_ready, q.size() != 2);
      else pass_cnt++;
      r_out_ready = 1'b1; #1;
      total_cnt++;
      if (r_in_ready !== (q.size() != 2))
        $display("FAIL rnd_ready_or1[%0d]: got %b want %b", cyc, r_in_ready, q.size() != 2);
      else pass_cnt++;
      r_out_ready = ($urandom_range(2) != 0); #1;
      total_cnt++;
      if (r_count !== 2'(q.size()) || r_out_valid !== (q.size() != 0))
        $display("FAIL rnd_count[%0d]: got c=%0d v=%b want %0d", cyc, r_count, r_out_valid, q.size());
      else pass_cnt++;
      if (r_out_valid && r_out_ready) begin
        total_cnt++;
        if (q.size() == 0) begin
          $display("FAIL rnd_spurious[%0d]: got d=%h want no output", cyc, r_out_data);
        end else begin
          exp_d = q.pop_front();
          if (r_out_data !== exp_d) $display("FAIL rnd_data[%0d]: got %h want %h", cyc, r_out_data, exp_d);
          else pass_cnt++;
        end
      end
      fired = r_in_valid & r_in_ready;
      if (fired) q.push_back(r_in_data);
      tick();
      if (fired) r_in_valid = 1'b0;
    end
    r_in_valid = 1'b0; r_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (r_out_valid) begin
        total_cnt++;
        if (q.size() == 0) begin
          $display("FAIL rnd_drain_spurious: got d=%h want no output", r_out_data);
        end else begin
          exp_d = q.pop_front();
          if (r_out_data !== exp_d) $display("FAIL rnd_drain_data: got %h want %h", r_out_data, exp_d);
          else pass_cnt++;
        end
      end
      tick();
    end
    total_cnt++;
    if (q.size() != 0 || r_count !== 2'd0)
      $display("FAIL rnd_lost: got %0d undelivered entries, count=%0d want 0 0", q.size(), r_count);
    else pass_cnt++;
  endtask

  initial begin
    r_reset = 1'b1; r_flush = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0; r_in_data = '0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_reset_mid();
`ifdef PIPE_ELASTIC_STATS_EN
    test_stats();
`endif
    test_random64();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
